quad_decoder_multi: RTL and testbench

Multi-channel quadrature encoder interface for the motor-control datapath. One instance serves N_CH encoders, sharing one sample-window timer. Each channel provides:
- a signed per-window edge count (speed);
- a free-running signed position;
- a sticky illegal-transition flag.

All channels are sampled by the same single `clk`. Outputs are consumed by the SPI/register front end and the speed loop.

---
 rtl/quad_decoder_multi.sv | 207 ++++++++++++++++++++
 tb/tb_quad_decoder_multi.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_decoder_multi.sv
// Multi-channel quadrature decoder: per-channel position, windowed speed and sticky illegal flag,
// all channels sharing one sample-window timer. Define QD_FILTER_EN to add a glitch filter.
module quad_decoder_multi #(
    parameter int unsigned N_CH        = 2,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned POS_W       = 32,
    parameter int unsigned WINDOW      = 200000,
    parameter int unsigned SYNC_STAGES = 3,
    parameter int unsigned FILT_LEN    = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_CH-1:0]         quad_a,
    input  logic [N_CH-1:0]         quad_b,
    input  logic [N_CH-1:0]         clear_pos,
    input  logic [N_CH-1:0]         err_clear,
    output logic [N_CH*CNT_W-1:0]   speed,
    output logic [N_CH*POS_W-1:0]   position,
    output logic                    sample_valid,
    output logic [N_CH-1:0]         illegal_err
);

    // A bits occupy [N_CH-1:0], B bits occupy [2*N_CH-1:N_CH] throughout.
    localparam int unsigned NB    = 2 * N_CH;
    localparam int unsigned TMR_W = $clog2(WINDOW);

    localparam logic [TMR_W-1:0]        TmrLast = TMR_W'(WINDOW - 1);
    localparam logic signed [CNT_W-1:0] AccMax  = {1'b0, {(CNT_W - 1){1'b1}}};
    localparam logic signed [CNT_W-1:0] AccMin  = {1'b1, {(CNT_W - 1){1'b0}}};

    // ---------------------------------------------------------------------------------------
    // Input synchronisers
    // ---------------------------------------------------------------------------------------
    logic [NB-1:0] sync_q [SYNC_STAGES];
    logic [NB-1:0] sync_d [SYNC_STAGES];

    always_comb begin
        sync_d[0] = {quad_b, quad_a};
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q <= sync_d;
        end
    end

    logic [NB-1:0] cur_ab;

`ifdef QD_FILTER_EN
    // ---------------------------------------------------------------------------------------
    // Per-bit stability filter: follow the raw bit only after FILT_LEN consecutive differing cycles
    // ---------------------------------------------------------------------------------------
    localparam int unsigned FCNT_W = $clog2(FILT_LEN + 1);

    logic [NB-1:0]     filt_q;
    logic [NB-1:0]     filt_d;
    logic [FCNT_W-1:0] fcnt_q [NB];
    logic [FCNT_W-1:0] fcnt_d [NB];

    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < NB; i++) begin
            fcnt_d[i] = '0;
            if (sync_q[SYNC_STAGES-1][i] != filt_q[i]) begin
                if (fcnt_q[i] == FCNT_W'(FILT_LEN - 1)) begin
                    filt_d[i] = sync_q[SYNC_STAGES-1][i];
                end else begin
                    fcnt_d[i] = fcnt_q[i] + FCNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_q <= '0;
            for (int i = 0; i < NB; i++) begin
                fcnt_q[i] <= '0;
            end
        end else begin
            filt_q <= filt_d;
            fcnt_q <= fcnt_d;
        end
    end

    assign cur_ab = filt_q;
`else
    assign cur_ab = sync_q[SYNC_STAGES-1];
`endif

    // ---------------------------------------------------------------------------------------
    // Transition decode
    // ---------------------------------------------------------------------------------------
    logic [NB-1:0]   prev_q;
    logic [NB-1:0]   prev_d;
    logic [N_CH-1:0] chg_a;
    logic [N_CH-1:0] chg_b;
    logic [N_CH-1:0] step;
    logic [N_CH-1:0] dir_up;
    logic [N_CH-1:0] illegal;

    assign prev_d = cur_ab;

    always_comb begin
        chg_a   = prev_q[N_CH-1:0] ^ cur_ab[N_CH-1:0];
        chg_b   = prev_q[NB-1:N_CH] ^ cur_ab[NB-1:N_CH];
        step    = chg_a ^ chg_b;
        dir_up  = cur_ab[N_CH-1:0] ^ prev_q[NB-1:N_CH];
        illegal = chg_a & chg_b;
    end

    // ---------------------------------------------------------------------------------------
    // Window timer and per-channel state
    // ---------------------------------------------------------------------------------------
    logic [TMR_W-1:0] timer_q;
    logic [TMR_W-1:0] timer_d;
    logic             terminal;
    logic             valid_q;
    logic             valid_d;
    logic [N_CH-1:0]  err_q;
    logic [N_CH-1:0]  err_d;

    logic signed [POS_W-1:0] pos_q    [N_CH];
    logic signed [POS_W-1:0] pos_d    [N_CH];
    logic signed [CNT_W-1:0] acc_q    [N_CH];
    logic signed [CNT_W-1:0] acc_d    [N_CH];
    logic signed [CNT_W-1:0] acc_step [N_CH];
    logic signed [CNT_W-1:0] speed_q  [N_CH];
    logic signed [CNT_W-1:0] speed_d  [N_CH];

    assign terminal = (timer_q == TmrLast);

    always_comb begin
        timer_d = terminal ? '0 : timer_q + TMR_W'(1);
        valid_d = terminal;
        // Setting beats clearing when both happen in the same cycle.
        err_d   = (err_q & ~err_clear) | illegal;

        for (int i = 0; i < N_CH; i++) begin
            acc_step[i] = acc_q[i];
            if (step[i]) begin
                if (dir_up[i]) begin
                    if (acc_q[i] != AccMax) acc_step[i] = acc_q[i] + CNT_W'(1);
                end else begin
                    if (acc_q[i] != AccMin) acc_step[i] = acc_q[i] - CNT_W'(1);
                end
            end

            // The terminal cycle's own step lands in the closing window, so nothing is lost.
            if (terminal) begin
                speed_d[i] = acc_step[i];
                acc_d[i]   = '0;
            end else begin
                speed_d[i] = speed_q[i];
                acc_d[i]   = acc_step[i];
            end

            pos_d[i] = pos_q[i];
            if (clear_pos[i]) begin
                pos_d[i] = '0;
            end else if (step[i]) begin
                pos_d[i] = dir_up[i] ? pos_q[i] + POS_W'(1) : pos_q[i] - POS_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q  <= '0;
            timer_q <= '0;
            valid_q <= 1'b0;
            err_q   <= '0;
            for (int i = 0; i < N_CH; i++) begin
                pos_q[i]   <= '0;
                acc_q[i]   <= '0;
                speed_q[i] <= '0;
            end
        end else begin
            prev_q  <= prev_d;
            timer_q <= timer_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            pos_q   <= pos_d;
            acc_q   <= acc_d;
            speed_q <= speed_d;
        end
    end

    // ---------------------------------------------------------------------------------------
    // Output packing
    // ---------------------------------------------------------------------------------------
    for (genvar g = 0; g < N_CH; g++) begin : g_out
        assign speed[g*CNT_W +: CNT_W]    = speed_q[g];
        assign position[g*POS_W +: POS_W] = pos_q[g];
    end

    assign sample_valid = valid_q;
    assign illegal_err  = err_q;

endmodule

// File: tb/tb_quad_decoder_multi.sv
// Bench for quad_decoder_multi: directed scenarios plus random stimulus, checked every cycle
// against a Gray-code-index reference model. Honours QD_FILTER_EN when defined.
module tb_quad_decoder_multi;

    localparam int unsigned N_CH        = 2;
    localparam int unsigned CNT_W       = 16;
    localparam int unsigned SAT_W       = 4;
    localparam int unsigned POS_W       = 32;
    localparam int unsigned WINDOW      = 100;
    localparam int unsigned SYNC_STAGES = 3;
    localparam int unsigned FILT_LEN    = 4;
`ifdef QD_FILTER_EN
    localparam int LAT      = SYNC_STAGES + FILT_LEN;
    localparam int MIN_HOLD = FILT_LEN;
`else
    localparam int LAT      = SYNC_STAGES;
    localparam int MIN_HOLD = 1;
`endif

    logic                  clk       = 1'b0;
    logic                  reset     = 1'b0;
    logic [N_CH-1:0]       quad_a    = '0;
    logic [N_CH-1:0]       quad_b    = '0;
    logic [N_CH-1:0]       clear_pos = '0;
    logic [N_CH-1:0]       err_clear = '0;
    logic [N_CH*CNT_W-1:0] speed;
    logic [N_CH*POS_W-1:0] position;
    logic                  sample_valid;
    logic [N_CH-1:0]       illegal_err;
    logic [N_CH*SAT_W-1:0] sat_speed;
    logic [N_CH*POS_W-1:0] sat_position;
    logic                  sat_valid;
    logic [N_CH-1:0]       sat_err;

    always #5 clk = ~clk;

    quad_decoder_multi #(
        .N_CH(N_CH), .CNT_W(CNT_W), .POS_W(POS_W), .WINDOW(WINDOW),
        .SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)
    ) u_dut (
        .clk(clk), .reset(reset), .quad_a(quad_a), .quad_b(quad_b),
        .clear_pos(clear_pos), .err_clear(err_clear), .speed(speed), .position(position),
        .sample_valid(sample_valid), .illegal_err(illegal_err)
    );

    // Narrow accumulator copy to exercise saturation on the same stimulus.
    quad_decoder_multi #(
        .N_CH(N_CH), .CNT_W(SAT_W), .POS_W(POS_W), .WINDOW(WINDOW),
        .SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)
    ) u_sat (
        .clk(clk), .reset(reset), .quad_a(quad_a), .quad_b(quad_b),
        .clear_pos(clear_pos), .err_clear(err_clear), .speed(sat_speed),
        .position(sat_position), .sample_valid(sat_valid), .illegal_err(sat_err)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%08h want 0x%08h at %0t", tag, got, want, $time);
    endtask

    // ---------------------------------------------------------------------------------------
    // Reference model: track each channel's Gray index; index delta 1/3/2 = up/down/illegal.
    // ---------------------------------------------------------------------------------------
    logic [1:0] gray  [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    logic [1:0] phase [N_CH];
    logic [1:0] m_ab  [N_CH];
    logic [1:0] hist  [N_CH][LAT+2];
    int         m_pos [N_CH];
    int         m_acc [N_CH];
    int         m_acc4[N_CH];
    int         m_spd [N_CH];
    int         m_spd4[N_CH];
    logic [N_CH-1:0] m_err;
    logic       m_valid;
    int         m_tmr;

    function automatic int gidx(input logic [1:0] ab);
        for (int k = 0; k < 4; k++) if (gray[k] == ab) return k;
        return 0;
    endfunction

    function automatic int sat(input int v, input int w);
        int hi = (1 << (w - 1)) - 1;
        int lo = -(1 << (w - 1));
        return (v > hi) ? hi : (v < lo) ? lo : v;
    endfunction

    task automatic model_reset();
        for (int ch = 0; ch < N_CH; ch++) begin
            for (int k = 0; k < LAT + 2; k++) hist[ch][k] = 2'b00;
            m_pos[ch] = 0; m_acc[ch] = 0; m_acc4[ch] = 0; m_spd[ch] = 0; m_spd4[ch] = 0;
        end
        m_err = '0; m_valid = 1'b0; m_tmr = 0;
    endtask

    task automatic model_step();
        bit term = (m_tmr == WINDOW - 1);
        for (int ch = 0; ch < N_CH; ch++) begin
            int mv, d;
            for (int k = LAT + 1; k > 0; k--) hist[ch][k] = hist[ch][k-1];
            hist[ch][0] = m_ab[ch];
            // Pins reach the decoder LAT cycles after being sampled.
            mv = (gidx(hist[ch][LAT]) - gidx(hist[ch][LAT+1]) + 4) % 4;
            d  = (mv == 1) ? 1 : (mv == 3) ? -1 : 0;
            m_err[ch]  = (m_err[ch] & ~err_clear[ch]) | (mv == 2);
            m_pos[ch]  = clear_pos[ch] ? 0 : m_pos[ch] + d;
            m_acc[ch]  = sat(m_acc[ch] + d, CNT_W);
            m_acc4[ch] = sat(m_acc4[ch] + d, SAT_W);
            if (term) begin
                m_spd[ch] = m_acc[ch]; m_spd4[ch] = m_acc4[ch];
                m_acc[ch] = 0;         m_acc4[ch] = 0;
            end
        end
        m_valid = term;
        m_tmr   = term ? 0 : m_tmr + 1;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) model_reset();
        else       model_step();
    end

    function automatic int sx(input int ch);
        return int'($signed(speed[ch*CNT_W +: CNT_W]));
    endfunction

    function automatic int sx4(input int ch);
        return int'($signed(sat_speed[ch*SAT_W +: SAT_W]));
    endfunction

    task automatic compare_all();
        for (int ch = 0; ch < N_CH; ch++) begin
            check($sformatf("pos%0d", ch), position[ch*POS_W +: POS_W], m_pos[ch]);
            check($sformatf("speed%0d", ch), sx(ch), m_spd[ch]);
            check($sformatf("sat_speed%0d", ch), sx4(ch), m_spd4[ch]);
            check($sformatf("sat_pos%0d", ch), sat_position[ch*POS_W +: POS_W], m_pos[ch]);
        end
        check("valid", 32'(sample_valid), 32'(m_valid));
        check("sat_valid", 32'(sat_valid), 32'(m_valid));
        check("err", 32'(illegal_err), 32'(m_err));
        check("sat_err", 32'(sat_err), 32'(m_err));
    endtask

    always @(negedge clk) if (chk_en) compare_all();

    // ---------------------------------------------------------------------------------------
    // Stimulus helpers (inputs change 1 time unit after the rising edge)
    // ---------------------------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // delta: +1 forward, -1 reverse, 2 illegal (both pins flip)
    task automatic move(input int ch, input int delta);
        phase[ch]  = phase[ch] + 2'(delta);
        m_ab[ch]   = gray[phase[ch]];
        quad_a[ch] = m_ab[ch][1];
        quad_b[ch] = m_ab[ch][0];
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        tick(1);
        while (!sample_valid && n < 3 * WINDOW) begin tick(1); n++; end
        check({tag, "_seen"}, 32'(sample_valid), 32'd1);
    endtask

    function automatic logic [31:0] pos_of(input int ch);
        return position[ch*POS_W +: POS_W];
    endfunction

    initial begin
        #(10 * 60000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int r;
        int n;
        for (int ch = 0; ch < N_CH; ch++) begin phase[ch] = 2'd0; m_ab[ch] = 2'b00; end
        #2 reset = 1'b1;
        tick(2);
        check("rst_pos0", pos_of(0), 0);
        check("rst_pos1", pos_of(1), 0);
        check("rst_speed", speed[31:0], 0);
        check("rst_valid", 32'(sample_valid), 0);
        check("rst_err", 32'(illegal_err), 0);
        reset  = 1'b0;
        chk_en = 1'b1;

        // Forward rotation on ch0, one transition every 5 cycles.
        for (int t = 0; t < 80; t++) begin
            move(0, 1);
            for (int c = 0; c < 5; c++) begin
                tick(1);
                if (sample_valid && t >= 25 && t < 75) begin
                    check("fwd_speed0", sx(0), 20);
                    check("fwd_speed1", sx(1), 0);
                end
            end
        end
        tick(LAT + 2);
        check("fwd_pos", pos_of(0), 80);

        // Reverse rotation on ch1.
        for (int t = 0; t < 40; t++) begin move(1, -1); tick(5); end
        tick(LAT + 2);
        check("rev_pos", pos_of(1), 32'hFFFF_FFD8);
        check("rev_err", 32'(illegal_err[1]), 0);

        // Step decoded exactly on the terminal cycle.
        wait_valid("bnd_a");
        tick(WINDOW - LAT - 1);
        move(0, 1);
        wait_valid("bnd_b");
        check("bnd_speed0", sx(0), 1);
        check("bnd_speed1", sx(1), 0);
        check("bnd_pos", pos_of(0), 81);
        wait_valid("bnd_c");
        check("bnd_next_speed0", sx(0), 0);

        // Illegal transition, clear, then illegal coinciding with clear.
        move(0, 2);
        tick(LAT + 2);
        check("ill_err", 32'(illegal_err[0]), 1);
        check("ill_pos", pos_of(0), 81);
        err_clear[0] = 1'b1; tick(1); err_clear[0] = 1'b0;
        check("ill_clr", 32'(illegal_err[0]), 0);
        move(0, 2);
        tick(LAT);
        err_clear[0] = 1'b1; tick(1); err_clear[0] = 1'b0;
        check("ill_set_wins", 32'(illegal_err[0]), 1);
        tick(2);
        check("ill_sticky", 32'(illegal_err[0]), 1);
        check("ill_err1", 32'(illegal_err[1]), 0);

        // Position clear coinciding with a step.
        for (int i = 0; i < 24; i++) begin move(0, -1); tick(MIN_HOLD); end
        tick(LAT + 2);
        check("clr_pre", pos_of(0), 57);
        move(0, 1);
        tick(LAT);
        clear_pos[0] = 1'b1; tick(1); clear_pos[0] = 1'b0;
        check("clr_pos", pos_of(0), 0);
        tick(3);
        check("clr_hold", pos_of(0), 0);

        // 12 forward steps in one window: narrow accumulator saturates.
        wait_valid("sat_a");
        for (int i = 0; i < 12; i++) begin move(0, 1); tick(MIN_HOLD); end
        wait_valid("sat_b");
        check("sat_speed4", sx4(0), 7);
        check("sat_speed16", sx(0), 12);

        // Reset in the middle of a window.
        wait_valid("rst_a");
        tick(50);
        reset = 1'b1;
        #1;
        check("mid_rst_pos0", pos_of(0), 0);
        check("mid_rst_pos1", pos_of(1), 0);
        check("mid_rst_speed", speed[31:0], 0);
        check("mid_rst_sat", 32'(sat_speed), 0);
        check("mid_rst_err", 32'(illegal_err), 0);
        for (int ch = 0; ch < N_CH; ch++) begin
            phase[ch] = 2'd0; m_ab[ch] = 2'b00; quad_a[ch] = 1'b0; quad_b[ch] = 1'b0;
        end
        tick(3);
        reset = 1'b0;
        n = 0;
        while (!sample_valid && n < 3 * WINDOW) begin tick(1); n++; end
        check("rst_window", n, WINDOW);

`ifdef QD_FILTER_EN
        // Short glitch on A is filtered; a properly held transition is counted.
        quad_a[0] = ~m_ab[0][1];
        tick(FILT_LEN - 1);
        quad_a[0] = m_ab[0][1];
        tick(LAT + 4);
        check("glitch_pos", pos_of(0), 0);
        move(0, 1);
        tick(FILT_LEN + LAT + 2);
        check("filt_step_pos", pos_of(0), 1);
`endif

        // Random traffic on all channels.
        for (int s = 0; s < 300; s++) begin
            for (int ch = 0; ch < N_CH; ch++) begin
                r = $urandom_range(0, 15);
                if (r < 6)       move(ch, 1);
                else if (r < 12) move(ch, -1);
                else if (r == 14) move(ch, 2);
                clear_pos[ch] = ($urandom_range(0, 31) == 0);
                err_clear[ch] = ($urandom_range(0, 15) == 0);
            end
            tick(1);
            clear_pos = '0;
            err_clear = '0;
            tick(MIN_HOLD - 1 + int'($urandom_range(0, 3)));
        end
        tick(LAT + 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
